// File: rtl/ps2_host_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, serialise
// one byte on device clock edges, check the device ack, report done/errors.
module ps2_host_command_tx #(
    parameter int unsigned INHIBIT_CYCLES    = 6000,
    parameter int unsigned FIRST_EDGE_CYCLES = 750000,
    parameter int unsigned BIT_CYCLES        = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       timeout_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned TMO_W  = 20;
    localparam int unsigned INH_W  = 13;
    localparam int unsigned IDX_W  = 4;

    localparam logic [TMO_W-1:0] FIRST_LOAD = TMO_W'(FIRST_EDGE_CYCLES);
    localparam logic [TMO_W-1:0] BIT_LOAD   = TMO_W'(BIT_CYCLES);
    localparam logic [INH_W-1:0] INH_LOAD   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PAR_IDX    = IDX_W'(8);
    localparam logic [IDX_W-1:0] STOP_IDX   = IDX_W'(9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Synchroniser stages and edge detect
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;
    logic       clk_s;
    logic       dat_s;
    logic       fe;

    // Datapath registers and their next values
    logic [BYTE_W-1:0] cmd_q;
    logic [BYTE_W-1:0] cmd_next;
    logic              parity_q;
    logic              parity_next;
    logic [INH_W-1:0]  inh_cnt;
    logic [INH_W-1:0]  inh_next;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  idx_next;
    logic              ack_flag;
    logic              ack_flag_next;
    logic              tmo_flag;
    logic              tmo_flag_next;

    // Registered line drives and next values of all registered outputs
    logic clk_low;
    logic dat_low;
    logic clk_low_next;
    logic dat_low_next;
    logic busy_next;
    logic done_next;
    logic ack_error_next;
    logic timeout_error_next;

    // Open-drain drivers: only ever pull low or float
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign fe    = clk_prev & ~clk_s;

    // Two-flop synchronisers for both lines plus previous synced clock for edge detect
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_s;
        end
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic with counter, index and flag updates
    always_comb begin
        state_next    = state;
        cmd_next      = cmd_q;
        parity_next   = parity_q;
        inh_next      = inh_cnt;
        tmo_next      = tmo_cnt;
        idx_next      = bit_idx;
        ack_flag_next = ack_flag;
        tmo_flag_next = tmo_flag;

        case (state)
            S_IDLE: begin
                ack_flag_next = 1'b0;
                tmo_flag_next = 1'b0;
                if (send) begin
                    cmd_next    = command;
                    parity_next = ~^command;
                    inh_next    = INH_LOAD;
                    state_next  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt == '0) begin
                    state_next = S_REQ;
                end else begin
                    inh_next = inh_cnt - INH_W'(1);
                end
            end
            S_REQ: begin
                tmo_next   = FIRST_LOAD;
                idx_next   = '0;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                // A device edge takes priority over an expiring counter
                if (fe) begin
                    idx_next = bit_idx + IDX_W'(1);
                    tmo_next = BIT_LOAD;
                    if (bit_idx == STOP_IDX) begin
                        state_next = S_ACK;
                    end
                end else if (tmo_cnt == '0) begin
                    tmo_flag_next = 1'b1;
                    ack_flag_next = 1'b0;
                    state_next    = S_DONE;
                end else begin
                    tmo_next = tmo_cnt - TMO_W'(1);
                end
            end
            S_ACK: begin
                if (fe) begin
                    ack_flag_next = dat_s;
                    tmo_next      = BIT_LOAD;
                    state_next    = S_RELEASE;
                end else if (tmo_cnt == '0) begin
                    tmo_flag_next = 1'b1;
                    ack_flag_next = 1'b0;
                    state_next    = S_DONE;
                end else begin
                    tmo_next = tmo_cnt - TMO_W'(1);
                end
            end
            S_RELEASE: begin
                if (clk_s && dat_s) begin
                    state_next = S_DONE;
                end else if (tmo_cnt == '0) begin
                    tmo_flag_next = 1'b1;
                    ack_flag_next = 1'b0;
                    state_next    = S_DONE;
                end else begin
                    tmo_next = tmo_cnt - TMO_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered status and line-drive outputs
    always_comb begin
        busy_next          = (state_next != S_IDLE) && (state_next != S_DONE);
        done_next          = (state_next == S_DONE);
        ack_error_next     = done_next & ack_flag_next;
        timeout_error_next = done_next & tmo_flag_next;
        clk_low_next       = (state_next == S_INHIBIT);
        dat_low_next       = dat_low;

        case (state_next)
            S_IDLE, S_DONE, S_RELEASE: dat_low_next = 1'b0;
            S_INHIBIT:                 dat_low_next = (inh_next == '0);
            S_REQ:                     dat_low_next = 1'b1;
            default:                   dat_low_next = dat_low;
        endcase

        // Data only changes right after a device falling edge, while its clock is low
        if ((state == S_SHIFT) && fe) begin
            if (bit_idx < PAR_IDX) begin
                dat_low_next = ~cmd_q[bit_idx[2:0]];
            end else if (bit_idx == PAR_IDX) begin
                dat_low_next = ~parity_q;
            end else begin
                dat_low_next = 1'b0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            cmd_q         <= '0;
            parity_q      <= 1'b0;
            inh_cnt       <= '0;
            tmo_cnt       <= '0;
            bit_idx       <= '0;
            ack_flag      <= 1'b0;
            tmo_flag      <= 1'b0;
            clk_low       <= 1'b0;
            dat_low       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ack_error     <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            cmd_q         <= cmd_next;
            parity_q      <= parity_next;
            inh_cnt       <= inh_next;
            tmo_cnt       <= tmo_next;
            bit_idx       <= idx_next;
            ack_flag      <= ack_flag_next;
            tmo_flag      <= tmo_flag_next;
            clk_low       <= clk_low_next;
            dat_low       <= dat_low_next;
            busy          <= busy_next;
            done          <= done_next;
            ack_error     <= ack_error_next;
            timeout_error <= timeout_error_next;
        end
    end

endmodule

// File: tb/tb_ps2_host_command_tx.sv
// Self-checking bench for ps2_host_command_tx with a behavioural PS/2 device.
module tb_ps2_host_command_tx;

    localparam int unsigned T_INH   = 40;
    localparam int unsigned T_FIRST = 2000;
    localparam int unsigned T_BIT   = 400;
    localparam int          BUDGET  = T_INH + T_FIRST + 12 * T_BIT + 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] command;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       timeout_error;
    wire        ps2_clk;
    wire        ps2_dat;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_host_command_tx #(
        .INHIBIT_CYCLES   (T_INH),
        .FIRST_EDGE_CYCLES(T_FIRST),
        .BIT_CYCLES       (T_BIT)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst_n),
        .send         (send),
        .command      (command),
        .busy         (busy),
        .done         (done),
        .ack_error    (ack_error),
        .timeout_error(timeout_error),
        .PS2_CLK      (ps2_clk),
        .PS2_DAT      (ps2_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Error flags may only be seen together with done
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done !== 1'b1 && (ack_error !== 1'b0 || timeout_error !== 1'b0))
            check("flags_without_done", 32'({ack_error, timeout_error}), 0);
    end

    // Expected device-side samples: start, data LSB first, odd parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] c);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = c[i];
        f[9]  = (($countones(c) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device model: measures inhibit, then clocks n_edges falling edges, sampling mid-high
    task automatic dev_run(input int half, input int n_edges, input bit give_ack,
                           output logic [10:0] smp, output int inh_len,
                           output int t_rel, output int t_fall);
        int w;
        smp = '0; inh_len = 0; t_rel = 0; t_fall = 0; w = 0;
        while (ps2_clk !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("inhibit_seen", 32'(w < 200), 1);
        while (ps2_clk === 1'b0 && inh_len < int'(T_INH) + 100) begin
            inh_len++;
            @(negedge clk);
        end
        t_rel = cyc;
        check("rts_dat_low", 32'(ps2_dat), 0);
        for (int k = 0; k < n_edges; k++) begin
            repeat (half) @(negedge clk);
            smp[k] = ps2_dat;
            if (k == 10 && give_ack) dev_dat_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b1;
            t_fall = cyc;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (dev_dat_low) begin
            repeat (half) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic host_send(input logic [7:0] cmd);
        @(negedge clk);
        command = cmd;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        check("busy_rise", 32'(busy), 1);
    endtask

    task automatic wait_done(output bit seen, output logic ae, output logic te, output int t_done);
        seen = 1'b0; ae = 1'b0; te = 1'b0; t_done = 0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1; ae = ack_error; te = timeout_error; t_done = cyc;
            end
        end
        check("done_seen", 32'(seen), 1);
    endtask

    // One full transfer against the device model, checked against the reference rules
    task automatic run_xfer(input logic [7:0] cmd, input int half, input int n_edges,
                            input bit give_ack, input string tag, output logic [10:0] smp);
        int inh_len, t_rel, t_fall, t_done, el;
        bit seen;
        logic ae, te;
        logic [10:0] exp_f, mask;
        exp_f = frame_of(cmd);
        fork
            dev_run(half, n_edges, give_ack, smp, inh_len, t_rel, t_fall);
            begin
                host_send(cmd);
                wait_done(seen, ae, te, t_done);
            end
        join
        check({tag, "_inhibit_len"}, 32'(inh_len), T_INH);
        if (n_edges > 0) begin
            mask = 11'((1 << n_edges) - 1);
            check({tag, "_frame"}, 32'(smp & mask), 32'(exp_f & mask));
        end
        if (n_edges < 11) begin
            el = (n_edges == 0) ? (t_done - t_rel) : (t_done - t_fall);
            check({tag, "_tmo_delay"},
                  32'(el >= int'((n_edges == 0) ? T_FIRST : T_BIT) &&
                      el <= int'((n_edges == 0) ? T_FIRST : T_BIT) + 12), 1);
            check({tag, "_timeout_error"}, 32'(te), 1);
            check({tag, "_ack_error"}, 32'(ae), 0);
        end else begin
            check({tag, "_timeout_error"}, 32'(te), 0);
            check({tag, "_ack_error"}, 32'(ae), 32'(!give_ack));
        end
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_lines_after"}, 32'({ps2_clk, ps2_dat}), 32'h3);
    endtask

    initial begin
        logic [10:0] smp;
        logic [10:0] smp2;
        int inh_len, t_rel, t_fall, t_done, n_done;
        bit seen;
        logic ae, te;

        rst_n = 1'b0; send = 1'b0; command = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ack_error", 32'(ack_error), 0);
        check("rst_timeout_error", 32'(timeout_error), 0);
        check("rst_lines", 32'({ps2_clk, ps2_dat}), 32'h3);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed frames
        run_xfer(8'hED, 20, 11, 1'b1, "ed", smp);
        check("ed_frame_literal", 32'(smp), 32'(11'b11111011010));
        run_xfer(8'h07, 15, 11, 1'b1, "x07", smp);
        check("x07_parity", 32'(smp[9]), 0);
        run_xfer(8'hFF, 12, 11, 1'b1, "xff", smp);
        check("xff_parity", 32'(smp[9]), 1);
        run_xfer(8'hA5, 12, 11, 1'b0, "noack", smp);
        run_xfer(8'hF4, 10, 0, 1'b0, "nodev", smp);
        run_xfer(8'h3C, 10, 4, 1'b0, "stall", smp);

        // Randomized frames, device timing and ack behaviour
        for (int i = 0; i < 8; i++) begin
            run_xfer(8'($urandom), int'($urandom_range(8, 25)), 11,
                     ($urandom_range(0, 3) != 0), "rnd", smp);
        end

        // Reset during SHIFT: lines float next cycle, busy drops, no done pulse
        fork
            dev_run(10, 3, 1'b0, smp, inh_len, t_rel, t_fall);
            host_send(8'h00);
        join
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_lines", 32'({ps2_clk, ps2_dat}), 32'h3);
        check("midrst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        n_done = 0;
        repeat (T_BIT + 50) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 0);

        // Send held high while busy and through DONE: byte unchanged, restart only from IDLE
        fork
            dev_run(12, 11, 1'b1, smp2, inh_len, t_rel, t_fall);
            begin
                host_send(8'h5A);
                repeat (10) @(negedge clk);
                command = 8'hC3;
                send    = 1'b1;
                wait_done(seen, ae, te, t_done);
                check("busysend_flags", 32'({ae, te}), 0);
                @(negedge clk);
                check("busysend_idle_gap", 32'(busy), 0);
                @(negedge clk);
                check("busysend_restart", 32'(busy), 1);
                send = 1'b0;
            end
        join
        check("busysend_frame", 32'(smp2), 32'(frame_of(8'h5A)));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("final_lines", 32'({ps2_clk, ps2_dat}), 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_command_tx.md
Name: ps2_host_command_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Shares the open-drain PS2_CLK/PS2_DAT lines with the scan-code receive path in the keyboard subsystem.
- Performs the inhibit/request-to-send sequence, serialises the byte on device-generated clock edges, checks the device ack, and reports completion or error.
- `busy` lets the owning logic ignore receive-side activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 6000: CLOCK_50 cycles PS2_CLK is held low before the request (120 us at 50 MHz).
- FIRST_EDGE_CYCLES, 750000: maximum wait for the first device falling edge after clock release (15 ms).
- BIT_CYCLES, 100000: maximum wait between subsequent device falling edges, and for the final line release (2 ms).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-low reset.
- send  input  1  start request; sampled only in IDLE.
- command  input  8  byte to transmit; latched on the accepted `send`.
- busy  output  1  high from the cycle after an accepted `send` until `done`.
- done  output  1  one-cycle pulse at the end of every transfer.
- ack_error  output  1  valid with `done`: the device did not pull data low at the ack slot.
- timeout_error  output  1  valid with `done`: an edge wait expired.
- PS2_CLK  inout  1  open-drain; driven 0 or Z, never 1.
- PS2_DAT  inout  1  open-drain; driven 0 or Z, never 1.

Behaviour:
- Reset (reset==0 at a CLOCK_50 edge):
  - State goes to IDLE; both lines become Z on the next cycle.
  - busy, done, ack_error and timeout_error go to 0; counters clear.
  - Reset mid-transfer aborts with no `done` pulse.
- Input synchronisation:
  - PS2_CLK and PS2_DAT pass through 2-FF synchronisers.
  - A falling edge (`fe`) is synced-prev==1 and synced-now==0.
- Parity: odd, so parity = ~^command.
- Shift frame: 11 bits, {stop=1, parity, command[7:0], start=0}, LSB shifted first after start.
- FSM states and transitions:
  - IDLE: lines Z. On send==1, latch command, compute parity, go to INHIBIT. `send` in any other state is ignored.
  - INHIBIT: drive PS2_CLK=0 for INHIBIT_CYCLES cycles. In the last cycle also drive PS2_DAT=0 (start bit). Go to REQ.
  - REQ: release PS2_CLK (Z); hold PS2_DAT=0. Load the timeout counter with FIRST_EDGE_CYCLES. Go to SHIFT with bit_idx=0.
  - SHIFT:
    - On each `fe`: bit_idx 0..7 drive data bit (0 → drive 0, 1 → Z); bit_idx 8 drives parity; bit_idx 9 releases data (stop).
    - Increment bit_idx and reload the timeout with BIT_CYCLES.
    - After the `fe` with bit_idx==9, go to ACK.
  - ACK: on the next `fe`, sample synced PS2_DAT. 1 sets the ack_error flag. Go to RELEASE.
  - RELEASE: wait until synced PS2_CLK==1 and PS2_DAT==1, then go to DONE.
  - DONE: pulse done for 1 cycle with the error flags; busy drops in the same cycle; go to IDLE.
- Data changes only in the CLOCK_50 cycle after a detected `fe`, while the device clock is low.
- Timeout:
  - The counter decrements every cycle in SHIFT, ACK and RELEASE.
  - On reaching 0: release both lines, set timeout_error, go to DONE. ack_error is 0 in this case.
- Flag rules:
  - ack_error and timeout_error are held only during the `done` cycle; they are 0 otherwise.
  - Both are never 1 together.
- Simultaneous events:
  - `fe` in the same cycle the counter hits 0: the `fe` wins.
  - send==1 in the DONE cycle: ignored. The next `send` is accepted one cycle later, in IDLE.
- Latency: accepted `send` → PS2_CLK low on the next cycle, so busy rises 1 cycle after `send`.
- Widths:
  - Timeout counter: 20 bits, which covers 750000.
  - INHIBIT counter: 13 bits.
  - bit_idx: 4 bits.

Test Plan:
- Normal 0xED:
  - Stimulus: send 0xED with a device model clocking at 12.5 kHz, acking with data low.
  - Required: PS2_CLK low for 6000 cycles; device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses with both error flags 0; busy is 0 after done.
- Parity check:
  - Stimulus: send 0x07, then 0xFF.
  - Required: sampled parity bits are 0 and 1 respectively; done with no errors.
- No ack:
  - Stimulus: device leaves data high at clock 11.
  - Required: done with ack_error=1, timeout_error=0; lines Z afterwards.
- No device:
  - Stimulus: PS2_CLK stays high after REQ.
  - Required: after 750000 cycles, done with timeout_error=1; both lines Z.
- Device stalls after 4 edges:
  - Required: timeout_error after 100000 cycles from the last edge.
- Reset and ignored send:
  - Stimulus: reset=0 during SHIFT; separately, send while busy.
  - Required: after reset, lines Z next cycle, no done pulse, busy=0. The send-while-busy does not change the transmitted byte.
